// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
//   Shared decode constants and immediate helpers for the RV32IM execute
//   stage: opcodes, funct3/funct7 values, the canonical NOP and the divider
//   iteration count.
//   No ports (package).
// ---------------------------------------------------------------------------
package ex_pkg;

    // One quotient bit per divider iteration.
    localparam int DIV_STEPS = 32;

    // ADDI x0, x0, 0 -- what id_ex presents when it was held or flushed.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Major opcodes
    localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
    localparam logic [6:0] INST_LUI      = 7'b0110111;
    localparam logic [6:0] INST_AUIPC    = 7'b0010111;
    localparam logic [6:0] INST_JAL      = 7'b1101111;
    localparam logic [6:0] INST_JALR     = 7'b1100111;

    // funct7
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_M    = 7'b0000001;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] INST_ADD_SUB = 3'b000;
    localparam logic [2:0] INST_SLL     = 3'b001;
    localparam logic [2:0] INST_SLT     = 3'b010;
    localparam logic [2:0] INST_SLTU    = 3'b011;
    localparam logic [2:0] INST_XOR     = 3'b100;
    localparam logic [2:0] INST_SR      = 3'b101;
    localparam logic [2:0] INST_OR      = 3'b110;
    localparam logic [2:0] INST_AND     = 3'b111;

    // funct3 for the M extension
    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    // funct3 for branches
    localparam logic [2:0] INST_BEQ  = 3'b000;
    localparam logic [2:0] INST_BNE  = 3'b001;
    localparam logic [2:0] INST_BLT  = 3'b100;
    localparam logic [2:0] INST_BGE  = 3'b101;
    localparam logic [2:0] INST_BLTU = 3'b110;
    localparam logic [2:0] INST_BGEU = 3'b111;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/ex_div.sv
// ---------------------------------------------------------------------------
// ex_div
//   Iterative restoring divider on unsigned magnitudes, one quotient bit per
//   cycle for DIV_STEPS cycles. Signs and special cases are handled by the
//   caller.
//
// Ports
//   clk, rst    core clock, synchronous active-high reset
//   start       load dividend/divisor and begin (ignored while busy)
//   dividend    unsigned dividend magnitude
//   divisor     unsigned divisor magnitude
//   busy        an operation is in progress
//   done        high during the cycle that performs the final step
//   quotient    result, valid from the cycle after done until the next start
//   remainder   result, valid from the cycle after done until the next start
//
// Handshake: start is a one-cycle request accepted on the next edge when busy
// is low; busy stays high for exactly DIV_STEPS cycles; done marks the last of
// them, so a caller can move to its result state on the same edge the final
// bit is written.
// ---------------------------------------------------------------------------
module ex_div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = $clog2(DIV_STEPS);

    logic [31:0]      r_quot;
    logic [31:0]      r_rem;
    logic [31:0]      r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    // The dividend is shifted out of r_quot MSB-first into the partial
    // remainder while quotient bits fill in from the right.
    always_comb begin
        w_shift = {r_rem, r_quot[31]};
        w_diff  = w_shift - {1'b0, r_div};
        w_fits  = ~w_diff[32];
    end

    assign busy      = r_busy;
    assign done      = r_busy && (r_cnt == CNT_W'(DIV_STEPS - 1));
    assign quotient  = r_quot;
    assign remainder = r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start && !r_busy) begin
            r_quot <= dividend;
            r_rem  <= '0;
            r_div  <= divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_quot <= {r_quot[30:0], w_fits};
            r_rem  <= w_fits ? w_diff[31:0] : w_shift[31:0];
            r_cnt  <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex.sv
// ---------------------------------------------------------------------------
// ex
//   RV32IM execute stage. ALU, shifts, compares, branches, JAL/JALR and
//   single-cycle multiplies are combinational from the id_ex outputs.
//   DIV/DIVU/REM/REMU run on ex_div; hold_flag_o stalls the pipeline while
//   the divide is in flight and the result is written back in the DONE cycle.
//
// Ports
//   clk, rst      core clock, synchronous active-high reset
//   inst_i        instruction (INST_NOP when id_ex was held/flushed)
//   inst_addr_i   PC of inst_i
//   op1_i, op2_i  operands (rs1/PC, rs2/immediate)
//   rd_addr_i     destination register
//   reg_wen_i     instruction writes rd
//   rd_addr_o     writeback register
//   rd_data_o     writeback data
//   rd_wen_o      writeback enable (never for x0)
//   jump_addr_o   redirect target
//   jump_en_o     taken branch / JAL / JALR
//   hold_flag_o   divider busy, pipeline stall request
// ---------------------------------------------------------------------------
module ex
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wen_o,
    output logic [31:0] jump_addr_o,
    output logic        jump_en_o,
    output logic        hold_flag_o
);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    div_state_e r_state;
    div_state_e w_state_next;

    // ---------------- decode ----------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_div;

    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_funct7 = inst_i[31:25];
    assign w_is_div = (w_opcode == INST_TYPE_R_M) && (w_funct7 == FUNCT7_M) && w_funct3[2];

    // ---------------- combinational ALU ----------------
    logic [4:0]  w_sh;
    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic        w_lt;
    logic        w_ltu;
    logic        w_eq;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic        w_mul_s1;
    logic        w_mul_s2;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_mul_p;

    assign w_sh  = op2_i[4:0];
    assign w_add = op1_i + op2_i;
    assign w_sub = op1_i - op2_i;
    assign w_lt  = $signed(op1_i) < $signed(op2_i);
    assign w_ltu = op1_i < op2_i;
    assign w_eq  = op1_i == op2_i;
    assign w_sll = op1_i << w_sh;
    assign w_srl = op1_i >> w_sh;
    assign w_sra = $unsigned($signed(op1_i) >>> w_sh);

    // Operands are sign- or zero-extended to 64 bits; the 64-bit product
    // modulo 2^64 is then the exact product for every signedness mix.
    assign w_mul_s1 = (w_funct3 == INST_MULH) || (w_funct3 == INST_MULHSU);
    assign w_mul_s2 = (w_funct3 == INST_MULH);
    assign w_mul_a  = {{32{w_mul_s1 & op1_i[31]}}, op1_i};
    assign w_mul_b  = {{32{w_mul_s2 & op2_i[31]}}, op2_i};
    assign w_mul_p  = w_mul_a * w_mul_b;

    logic [31:0] w_alu_data;
    logic        w_alu_writes;
    logic        w_alu_jump;
    logic [31:0] w_alu_jaddr;

    always_comb begin
        w_alu_data   = '0;
        w_alu_writes = 1'b0;
        w_alu_jump   = 1'b0;
        w_alu_jaddr  = '0;
        unique case (w_opcode)
            INST_TYPE_I: begin
                w_alu_writes = 1'b1;
                unique case (w_funct3)
                    INST_ADD_SUB: w_alu_data = w_add;
                    INST_SLL:     w_alu_data = w_sll;
                    INST_SLT:     w_alu_data = {31'b0, w_lt};
                    INST_SLTU:    w_alu_data = {31'b0, w_ltu};
                    INST_XOR:     w_alu_data = op1_i ^ op2_i;
                    INST_SR:      w_alu_data = w_funct7[5] ? w_sra : w_srl;
                    INST_OR:      w_alu_data = op1_i | op2_i;
                    default:      w_alu_data = op1_i & op2_i;
                endcase
            end
            INST_TYPE_R_M: begin
                w_alu_writes = 1'b1;
                if (w_funct7 == FUNCT7_M) begin
                    unique case (w_funct3)
                        INST_MUL:    w_alu_data = w_mul_p[31:0];
                        INST_MULH,
                        INST_MULHSU,
                        INST_MULHU:  w_alu_data = w_mul_p[63:32];
                        default:     w_alu_data = '0;
                    endcase
                end else begin
                    unique case (w_funct3)
                        INST_ADD_SUB: w_alu_data = (w_funct7 == FUNCT7_ALT) ? w_sub : w_add;
                        INST_SLL:     w_alu_data = w_sll;
                        INST_SLT:     w_alu_data = {31'b0, w_lt};
                        INST_SLTU:    w_alu_data = {31'b0, w_ltu};
                        INST_XOR:     w_alu_data = op1_i ^ op2_i;
                        INST_SR:      w_alu_data = (w_funct7 == FUNCT7_ALT) ? w_sra : w_srl;
                        INST_OR:      w_alu_data = op1_i | op2_i;
                        default:      w_alu_data = op1_i & op2_i;
                    endcase
                end
            end
            INST_LUI: begin
                w_alu_writes = 1'b1;
                w_alu_data   = imm_u(inst_i);
            end
            INST_AUIPC: begin
                w_alu_writes = 1'b1;
                w_alu_data   = inst_addr_i + imm_u(inst_i);
            end
            INST_JAL: begin
                w_alu_writes = 1'b1;
                w_alu_data   = inst_addr_i + 32'd4;
                w_alu_jump   = 1'b1;
                w_alu_jaddr  = inst_addr_i + imm_j(inst_i);
            end
            INST_JALR: begin
                w_alu_writes = 1'b1;
                w_alu_data   = inst_addr_i + 32'd4;
                w_alu_jump   = 1'b1;
                w_alu_jaddr  = (op1_i + imm_i(inst_i)) & ~32'd1;
            end
            INST_TYPE_B: begin
                w_alu_jaddr = inst_addr_i + imm_b(inst_i);
                unique case (w_funct3)
                    INST_BEQ:  w_alu_jump = w_eq;
                    INST_BNE:  w_alu_jump = !w_eq;
                    INST_BLT:  w_alu_jump = w_lt;
                    INST_BGE:  w_alu_jump = !w_lt;
                    INST_BLTU: w_alu_jump = w_ltu;
                    INST_BGEU: w_alu_jump = !w_ltu;
                    default:   w_alu_jump = 1'b0;
                endcase
            end
            default: begin
                w_alu_writes = 1'b0;
            end
        endcase
    end

    // ---------------- divider ----------------
    logic        w_start_signed;
    logic        w_div_start;
    logic [31:0] w_dividend;
    logic [31:0] w_divisor;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_div_quot;
    logic [31:0] w_div_rem;

    // DIV and REM are the signed forms (funct3 bit 0 clear).
    assign w_start_signed = ~w_funct3[0];
    assign w_div_start    = (r_state == DIV_IDLE) && w_is_div;
    assign w_dividend     = (w_start_signed && op1_i[31]) ? -op1_i : op1_i;
    assign w_divisor      = (w_start_signed && op2_i[31]) ? -op2_i : op2_i;

    ex_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (w_dividend),
        .divisor   (w_divisor),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quot),
        .remainder (w_div_rem)
    );

    // Operands and destination captured when the divide is accepted; the
    // id_ex outputs become NOP for the rest of the operation.
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [1:0]  r_kind;   // funct3[1:0]: bit0 unsigned, bit1 remainder
    logic [4:0]  r_rd;
    logic        r_wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op1  <= '0;
            r_op2  <= '0;
            r_kind <= '0;
            r_rd   <= '0;
            r_wen  <= 1'b0;
        end else if (w_div_start) begin
            r_op1  <= op1_i;
            r_op2  <= op2_i;
            r_kind <= w_funct3[1:0];
            r_rd   <= rd_addr_i;
            r_wen  <= reg_wen_i;
        end
    end

    logic        w_r_signed;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_div_result;

    assign w_r_signed = ~r_kind[0];

    always_comb begin
        w_quot = w_div_quot;
        w_rem  = w_div_rem;
        if (r_op2 == 32'd0) begin
            w_quot = 32'hFFFF_FFFF;
            w_rem  = r_op1;
        end else if (w_r_signed && (r_op1 == 32'h8000_0000) && (r_op2 == 32'hFFFF_FFFF)) begin
            w_quot = 32'h8000_0000;
            w_rem  = 32'd0;
        end else begin
            if (w_r_signed && (r_op1[31] ^ r_op2[31])) begin
                w_quot = -w_div_quot;
            end
            if (w_r_signed && r_op1[31]) begin
                w_rem = -w_div_rem;
            end
        end
        w_div_result = r_kind[1] ? w_rem : w_quot;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            DIV_IDLE: if (w_is_div)   w_state_next = DIV_BUSY;
            DIV_BUSY: if (w_div_done) w_state_next = DIV_DONE;
            DIV_DONE: w_state_next = DIV_IDLE;
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // While a divide is in flight (and during reset) every non-latched output
    // is suppressed; only the DONE cycle writes back the latched destination.
    always_comb begin
        rd_addr_o   = '0;
        rd_data_o   = '0;
        rd_wen_o    = 1'b0;
        jump_addr_o = '0;
        jump_en_o   = 1'b0;
        hold_flag_o = 1'b0;
        if (!rst) begin
            unique case (r_state)
                DIV_IDLE: begin
                    if (w_is_div) begin
                        hold_flag_o = 1'b1;
                    end else begin
                        rd_addr_o   = rd_addr_i;
                        rd_data_o   = w_alu_data;
                        rd_wen_o    = reg_wen_i && w_alu_writes && (rd_addr_i != 5'd0);
                        jump_en_o   = w_alu_jump;
                        jump_addr_o = w_alu_jump ? w_alu_jaddr : 32'd0;
                    end
                end
                DIV_BUSY: begin
                    hold_flag_o = 1'b1;
                end
                DIV_DONE: begin
                    rd_addr_o = r_rd;
                    rd_data_o = w_div_result;
                    rd_wen_o  = r_wen && (r_rd != 5'd0);
                end
                default: begin
                    hold_flag_o = 1'b0;
                end
            endcase
        end
    end

    // The divider's own busy flag tracks the FSM exactly; it is kept as a
    // named net for waveform correlation with the ex state.
    logic w_unused_busy;
    assign w_unused_busy = w_div_busy;

endmodule
